// File: rtl/program_feeder.sv
// Program RAM + sequencer that plays the initiator side of the Run/DIN/Done handshake.
// Optional watchdog on the done wait: define FEEDER_WDT_EN (adds WDT_CYCLES and timeout).
module program_feeder #(
    parameter int N = 16,
    parameter int A = 4
`ifdef FEEDER_WDT_EN
    , parameter int WDT_CYCLES = 64
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [A-1:0] load_addr,
    input  logic [N:0]   load_data,
    input  logic [A:0]   prog_len,
    input  logic         start,
    input  logic         done_in,
    output logic [N-1:0] din_out,
    output logic         run_out,
    output logic         busy,
    output logic         finished,
    output logic [A-1:0] pc
`ifdef FEEDER_WDT_EN
    , output logic       timeout
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD_IMM, WAIT_DONE, FINISH} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [A:0]   len_q, len_d;
    logic         imm_past_q, imm_past_d;
    logic         wr_en;
    logic [N:0]   cur_word;
    logic [A:0]   pc_inc;
    logic [N:0]   mem [2**A];

`ifdef FEEDER_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign cur_word = mem[pc_q];
    // One bit wider than pc so the end-of-program compare cannot wrap.
    assign pc_inc   = {1'b0, pc_q} + (A+1)'(1);
    assign pc       = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        imm_past_d = imm_past_q;
        wr_en      = 1'b0;
        din_out    = '0;
        run_out    = 1'b0;
        busy       = 1'b1;
        finished   = 1'b0;
`ifdef FEEDER_WDT_EN
        cnt_d      = cnt_q;
        timeout    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (load_en) begin
                    wr_en = 1'b1;
                end else if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    state_d = (prog_len != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                run_out = 1'b1;
                din_out = cur_word[N-1:0];
`ifdef FEEDER_WDT_EN
                cnt_d   = '0;
`endif
                if (cur_word[N]) begin
                    // Remember whether the immediate slot lies past the program end;
                    // pc saturates at the top address instead of wrapping.
                    imm_past_d = (pc_inc >= len_q);
                    if (pc_q != '1) pc_d = pc_q + A'(1);
                    state_d = HOLD_IMM;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            HOLD_IMM, WAIT_DONE: begin
                din_out = (state_q == HOLD_IMM && imm_past_q) ? '0 : cur_word[N-1:0];
                if (done_in) begin
                    if (pc_inc >= len_q) begin
                        state_d = FINISH;
                    end else begin
                        pc_d    = pc_q + A'(1);
                        state_d = ISSUE;
                    end
                end
`ifdef FEEDER_WDT_EN
                else if (cnt_q == CW'(WDT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    pc_d    = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            FINISH: begin
                finished = 1'b1;
                pc_d     = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            imm_past_q <= 1'b0;
`ifdef FEEDER_WDT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            imm_past_q <= imm_past_d;
`ifdef FEEDER_WDT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[load_addr] <= load_data;
    end

endmodule
